// File: rtl/uart_rx_capture.sv
// uart_rx_capture: 8N1 serial line receiver feeding a show-ahead byte FIFO, with framing-error and overflow reporting.
// Define UART_RX_CAPTURE_PARITY_EN for 8E1 frames and an extra parity_err_o pulse output.
module uart_rx_capture #(
  parameter int FREQ       = 74_250_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        rx_i,
  input  logic                        pop_i,
  input  logic                        clear_i,
  output logic [7:0]                  data_o,
  output logic                        valid_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o,
  output logic                        frame_err_o,
  output logic                        overflow_o,
`ifdef UART_RX_CAPTURE_PARITY_EN
  output logic                        parity_err_o,
`endif
  output logic                        busy_o
);
  localparam int DIV  = FREQ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int TW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);
  localparam logic [TW-1:0] T_FULL = TW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA,
`ifdef UART_RX_CAPTURE_PARITY_EN
    S_PARITY,
`endif
    S_STOP, S_BREAK
  } state_t;

`ifdef UART_RX_CAPTURE_PARITY_EN
  localparam state_t S_AFTER_DATA = S_PARITY;
`else
  localparam state_t S_AFTER_DATA = S_STOP;
`endif

  logic          r_sync1, r_sync2, r_rxs_d;
  logic          w_rxs, w_fall, w_tick;
  state_t        r_state, w_next;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_push, r_frame_err;
  logic          w_load_half, w_load_full, w_shift_en, w_push_req, w_ferr_req, w_par_ok;

  assign w_rxs  = r_sync2;
  assign w_fall = r_rxs_d & ~w_rxs;
  assign w_tick = (r_timer == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
      r_rxs_d <= r_sync2;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_fall) w_next = S_START;
      S_START: if (w_tick) w_next = w_rxs ? S_IDLE : S_DATA;
      S_DATA:  if (w_tick && (r_bit_idx == 3'd7)) w_next = S_AFTER_DATA;
`ifdef UART_RX_CAPTURE_PARITY_EN
      S_PARITY: if (w_tick) w_next = S_STOP;
`endif
      S_STOP:  if (w_tick) w_next = w_rxs ? S_IDLE : S_BREAK;
      S_BREAK: if (w_rxs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_load_half = 1'b0;
    w_load_full = 1'b0;
    w_shift_en  = 1'b0;
    w_push_req  = 1'b0;
    w_ferr_req  = 1'b0;
    case (r_state)
      S_IDLE:  w_load_half = w_fall;
      S_START: w_load_full = w_tick & ~w_rxs;
      S_DATA: begin
        w_shift_en  = w_tick;
        w_load_full = w_tick;
      end
`ifdef UART_RX_CAPTURE_PARITY_EN
      S_PARITY: w_load_full = w_tick;
`endif
      S_STOP: begin
        w_push_req = w_tick & w_rxs & w_par_ok;
        w_ferr_req = w_tick & ~w_rxs;
      end
      default: ;
    endcase
  end

  assign busy_o      = (r_state != S_IDLE);
  assign frame_err_o = r_frame_err;

  // Timer idles at zero outside active bit periods, so a tick there is harmless.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_timer     <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_load_half)      r_timer <= T_HALF;
      else if (w_load_full) r_timer <= T_FULL;
      else if (!w_tick)     r_timer <= r_timer - TW'(1);
      if (w_load_half)     r_bit_idx <= '0;
      else if (w_shift_en) r_bit_idx <= r_bit_idx + 3'd1;
      if (w_shift_en) r_shift <= {w_rxs, r_shift[7:1]};
      r_push      <= w_push_req;
      r_frame_err <= w_ferr_req;
    end
  end

`ifdef UART_RX_CAPTURE_PARITY_EN
  logic r_parity_err, r_par_bad, w_perr_req;
  assign w_perr_req   = (r_state == S_PARITY) && w_tick && (^{r_shift, w_rxs});
  assign w_par_ok     = ~r_par_bad;
  assign parity_err_o = r_parity_err;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_parity_err <= 1'b0;
      r_par_bad    <= 1'b0;
    end else begin
      r_parity_err <= w_perr_req;
      if (w_load_half)     r_par_bad <= 1'b0;
      else if (w_perr_req) r_par_bad <= 1'b1;
    end
  end
`else
  assign w_par_ok = 1'b1;
`endif

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr, r_rptr, w_count;
  logic        w_full, w_empty, w_do_push, w_do_pop, r_overflow;

  assign w_count   = r_wptr - r_rptr;
  assign w_full    = (w_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty   = (w_count == '0);
  assign w_do_pop  = pop_i & ~w_empty & ~clear_i;
  // A push alongside clear always lands, even into a full FIFO, since clear discards the old contents.
  assign w_do_push = r_push & (clear_i | ~w_full | w_do_pop);

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= r_shift;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (clear_i)       r_rptr <= r_wptr;
      else if (w_do_pop) r_rptr <= r_rptr + (AW+1)'(1);
      if (clear_i)                          r_overflow <= 1'b0;
      else if (r_push && w_full && !pop_i)  r_overflow <= 1'b1;
    end
  end

  assign data_o     = w_empty ? 8'h00 : r_mem[r_rptr[AW-1:0]];
  assign valid_o    = ~w_empty;
  assign count_o    = w_count;
  assign overflow_o = r_overflow;
endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed bench for uart_rx_capture: instance A at default 644 cycles/bit, instance B at 33 cycles/bit for FIFO fill tests.
module tb_uart_rx_capture;
  localparam int DEPTH  = 16;
  localparam int DIV_A  = 644;  // 74_250_000 / 115200, truncated
  localparam int HALF_A = 322;
  localparam int DIV_B  = 33;   // 1_000_000 / 30_000, truncated
  localparam int HALF_B = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rx_a = 1'b1, pop_a = 1'b0, clr_a = 1'b0;
  logic rx_b = 1'b1, pop_b = 1'b0, clr_b = 1'b0;
  logic [7:0] data_a, data_b;
  logic [4:0] count_a, count_b;
  logic valid_a, ferr_a, ovf_a, busy_a;
  logic valid_b, ferr_b, ovf_b, busy_b;
`ifdef UART_RX_CAPTURE_PARITY_EN
  logic perr_a, perr_b;
`endif

  always #5 clk = ~clk;

  uart_rx_capture u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_a), .pop_i(pop_a), .clear_i(clr_a),
    .data_o(data_a), .valid_o(valid_a), .count_o(count_a), .frame_err_o(ferr_a),
    .overflow_o(ovf_a),
`ifdef UART_RX_CAPTURE_PARITY_EN
    .parity_err_o(perr_a),
`endif
    .busy_o(busy_a)
  );

  uart_rx_capture #(.FREQ(1_000_000), .BAUD(30_000), .FIFO_DEPTH(DEPTH)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_b), .pop_i(pop_b), .clear_i(clr_b),
    .data_o(data_b), .valid_o(valid_b), .count_o(count_b), .frame_err_o(ferr_b),
    .overflow_o(ovf_b),
`ifdef UART_RX_CAPTURE_PARITY_EN
    .parity_err_o(perr_b),
`endif
    .busy_o(busy_b)
  );

  logic       sel_b = 1'b0;
  logic [7:0] m_data;
  logic [4:0] m_count;
  logic       m_valid, m_ferr, m_ovf, m_busy;
  assign m_data  = sel_b ? data_b  : data_a;
  assign m_count = sel_b ? count_b : count_a;
  assign m_valid = sel_b ? valid_b : valid_a;
  assign m_ferr  = sel_b ? ferr_b  : ferr_a;
  assign m_ovf   = sel_b ? ovf_b   : ovf_a;
  assign m_busy  = sel_b ? busy_b  : busy_a;

  int n_tests = 0, n_fail = 0;
  int n_ferr = 0, exp_ferr = 0;
  int div_c = DIV_B, half_c = HALF_B;
  logic [7:0] q[$];
  logic exp_ovf = 1'b0;

  always @(negedge clk) if (m_ferr) n_ferr++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input logic v);
    if (sel_b) rx_b = v; else rx_a = v;
  endtask

  task automatic set_pop(input logic v);
    if (sel_b) pop_b = v; else pop_a = v;
  endtask

  task automatic set_clr(input logic v);
    if (sel_b) clr_b = v; else clr_a = v;
  endtask

  task automatic check_state(input string tag);
    chk({tag, " count"}, 32'(m_count), 32'(q.size()));
    chk({tag, " valid"}, 32'(m_valid), 32'(q.size() != 0));
    chk({tag, " data"},  32'(m_data),  (q.size() != 0) ? 32'(q[0]) : 32'h0);
    chk({tag, " overflow"}, 32'(m_ovf), 32'(exp_ovf));
    chk({tag, " frame_err cycles"}, 32'(n_ferr), 32'(exp_ferr));
    chk({tag, " busy"}, 32'(m_busy), 32'h0);
  endtask

  task automatic pop_check(input string tag);
    chk({tag, " valid"}, 32'(m_valid), 32'h1);
    chk({tag, " data"},  32'(m_data),  32'(q[0]));
    set_pop(1'b1);
    step(1);
    set_pop(1'b0);
    void'(q.pop_front());
  endtask

  // Called aligned one time unit after a rising edge; line must be idle high.
  task automatic send(input logic [7:0] b, input bit stop_bad, input bit pop_on_push,
                      input bit clr_on_push, input bit check_timing);
    set_rx(1'b0);
    step(div_c);
    for (int i = 0; i < 8; i++) begin
      set_rx(b[i]);
      step(div_c);
    end
    if (stop_bad) begin
      set_rx(1'b0);
      step(2 * div_c);
      exp_ferr++;
      set_rx(1'b1);
      step(div_c);
    end else begin
      set_rx(1'b1);
      step(half_c + 2);
      if (check_timing) chk("busy before stop sample", 32'(m_busy), 32'h1);
      step(1);
      if (check_timing) begin
        chk("busy after stop sample", 32'(m_busy), 32'h0);
        chk("count before push", 32'(m_count), 32'(q.size()));
      end
      set_pop(pop_on_push);
      set_clr(clr_on_push);
      if (clr_on_push) begin
        q.delete();
        exp_ovf = 1'b0;
        q.push_back(b);
      end else begin
        if (pop_on_push && q.size() != 0) begin
          chk("head popped on push cycle", 32'(m_data), 32'(q[0]));
          void'(q.pop_front());
        end
        if (q.size() < DEPTH) q.push_back(b);
        else exp_ovf = 1'b1;
      end
      step(1);
      set_pop(1'b0);
      set_clr(1'b0);
      if (check_timing) check_state("after push");
      step(div_c - half_c - 4);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    step(3);
    sel_b = 1'b0;
    check_state("reset A");
    sel_b = 1'b1;
    check_state("reset B");
    rst_n = 1'b1;
    step(2);

    // Instance B: FIFO boundaries
    set_pop(1'b1);
    step(1);
    set_pop(1'b0);
    check_state("pop when empty");
    send(8'h3C, 0, 1, 0, 1);
    pop_check("push+pop while empty");

    for (int i = 0; i <= 16; i++) send(8'(i), 0, 0, 0, i == 0);
    check_state("after 17 bytes");
    for (int i = 0; i < 16; i++) pop_check("drain 00..0F");
    check_state("drained");
    set_clr(1'b1);
    step(1);
    set_clr(1'b0);
    exp_ovf = 1'b0;
    check_state("after clear");

    for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 0, 0, 0, 0);
    check_state("refilled");
    send(8'h7E, 0, 1, 0, 1);
    check_state("push+pop while full");
    for (int i = 0; i < 16; i++) pop_check("drain 21..2F,7E");
    check_state("drained again");

    send(8'h5A, 0, 0, 0, 0);
    send(8'h6B, 0, 0, 1, 1);
    pop_check("clear with push");
    check_state("B done");

    // Instance A: default line rate
    sel_b  = 1'b0;
    div_c  = DIV_A;
    half_c = HALF_A;
    q.delete();
    exp_ovf = 1'b0;

    send(8'h55, 0, 0, 0, 1);
    check_state("byte 55");
    pop_check("byte 55");

    set_rx(1'b0);
    step(200);
    set_rx(1'b1);
    step(HALF_A + 2 - 200);
    chk("busy during glitch", 32'(m_busy), 32'h1);
    step(1);
    chk("busy after glitch", 32'(m_busy), 32'h0);
    step(DIV_A);
    check_state("after glitch");

    send(8'hA3, 1, 0, 0, 0);
    step(DIV_A);
    check_state("after frame error");
    send(8'h41, 0, 0, 0, 1);
    check_state("byte 41");

    set_rx(1'b0);
    step(DIV_A);
    for (int i = 0; i < 4; i++) step(DIV_A);  // bits 0..3 of 0xF0 are low
    set_rx(1'b1);
    step(DIV_A / 2);
    chk("busy in bit 4", 32'(m_busy), 32'h1);
    rst_n = 1'b0;
    #1;
    q.delete();
    exp_ovf = 1'b0;
    check_state("reset mid-frame");
    step(2);
    rst_n = 1'b1;
    step(6 * DIV_A);
    check_state("after aborted frame");

    send(8'h31, 0, 0, 0, 1);
    pop_check("byte 31");
    check_state("end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
